// File: rtl/cache_access_master_if.sv
// Client request/response and cache_access/cache_return bus bundle for cache_access_master.
// master = the initiator (DUT side), slave = client + responder side.
`ifndef OPCODE_LOAD
`define OPCODE_LOAD 5'b00000
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE 5'b01000
`endif

interface cache_access_master_if #(parameter int ID_W = 4);
  logic            req_valid;
  logic            req_ready;
  logic [63:0]     req_addr;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [63:0]     req_wdata;
  logic            req_ci;
  logic            req_wt;
  logic            resp_valid;
  logic            resp_ready;
  logic [63:0]     resp_rdata;
  logic [1:0]      resp_error;
  logic            resp_mmio;
  logic            acc_valid;
  logic [ID_W-1:0] acc_id;
  logic [63:0]     acc_addr;
  logic [4:0]      acc_opcode;
  logic [4:0]      acc_funct;
  logic [63:0]     acc_wdata;
  logic            acc_ci;
  logic            acc_wt;
  logic [1:0]      acc_error;
  logic            acc_full;
  logic            ret_valid;
  logic [ID_W-1:0] ret_id;
  logic [127:0]    ret_rdata;
  logic [1:0]      ret_error;
  logic            ret_mmio;

  modport master (
    input  req_valid, req_addr, req_store, req_funct3, req_wdata, req_ci, req_wt,
    output req_ready,
    output resp_valid, resp_rdata, resp_error, resp_mmio,
    input  resp_ready,
    output acc_valid, acc_id, acc_addr, acc_opcode, acc_funct, acc_wdata, acc_ci, acc_wt, acc_error,
    input  acc_full,
    input  ret_valid, ret_id, ret_rdata, ret_error, ret_mmio
  );

  modport slave (
    output req_valid, req_addr, req_store, req_funct3, req_wdata, req_ci, req_wt,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error, resp_mmio,
    output resp_ready,
    input  acc_valid, acc_id, acc_addr, acc_opcode, acc_funct, acc_wdata, acc_ci, acc_wt, acc_error,
    output acc_full,
    output ret_valid, ret_id, ret_rdata, ret_error, ret_mmio
  );
endinterface

// File: rtl/cache_access_master.sv
// Single-outstanding cache_access initiator: issue one load/store, wait for the id-matched return
// (or timeout), sign/zero-extend load data and hold the response until the client takes it.
module cache_access_master #(
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  cache_access_master_if.master  bus,
  output logic                   stray
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      state;
  logic [TW-1:0]   timer;
  logic [ID_W-1:0] id;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [63:0]     addr_q;
  logic [63:0]     wdata_q;
  logic            ci_q;
  logic            wt_q;
  logic [63:0]     rdata_q;
  logic [1:0]      err_q;
  logic            mmio_q;
  logic            match;
  logic [63:0]     ext;
  logic [63:0]     raw;
  logic            unused_hi;

  assign raw       = bus.ret_rdata[63:0];
  assign unused_hi = ^bus.ret_rdata[127:64];
  assign match     = bus.ret_valid && (bus.ret_id == id);

  // funct3[2] selects zero-extension; a 64-bit access has nothing to extend
  always_comb begin
    ext = raw;
    case (funct3_q[1:0])
      2'd0: ext = funct3_q[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'd1: ext = funct3_q[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'd2: ext = funct3_q[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      2'd3: ext = raw;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state    <= S_IDLE;
      timer    <= '0;
      id       <= '0;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      ci_q     <= 1'b0;
      wt_q     <= 1'b0;
      rdata_q  <= 64'd0;
      err_q    <= 2'b00;
      mmio_q   <= 1'b0;
      stray    <= 1'b0;
    end else begin
      if (bus.ret_valid && (state != S_WAIT || bus.ret_id != id)) stray <= 1'b1;
      case (state)
        S_IDLE: if (bus.req_valid) begin
          addr_q   <= bus.req_addr;
          store_q  <= bus.req_store;
          funct3_q <= bus.req_funct3;
          wdata_q  <= bus.req_wdata;
          ci_q     <= bus.req_ci;
          wt_q     <= bus.req_wt;
          state    <= S_ISSUE;
        end
        S_ISSUE: if (!bus.acc_full) begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // a match on the final timer cycle still wins over the timeout
          if (match) begin
            mmio_q  <= bus.ret_mmio;
            err_q   <= {1'b0, |bus.ret_error};
            rdata_q <= (store_q || (|bus.ret_error)) ? 64'd0 : ext;
            state   <= S_RESP;
          end else if (timer == T_LAST) begin
            mmio_q  <= 1'b0;
            err_q   <= 2'b10;
            rdata_q <= 64'd0;
            state   <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: if (bus.resp_ready) begin
          id    <= id + 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.acc_valid  = (state == S_ISSUE) && !bus.acc_full;
  assign bus.acc_id     = id;
  assign bus.acc_addr   = addr_q;
  assign bus.acc_opcode = store_q ? `OPCODE_STORE : `OPCODE_LOAD;
  assign bus.acc_funct  = {2'b00, funct3_q};
  assign bus.acc_wdata  = wdata_q;
  assign bus.acc_ci     = ci_q;
  assign bus.acc_wt     = wt_q;
  assign bus.acc_error  = 2'b00;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = err_q;
  assign bus.resp_mmio  = mmio_q;
endmodule
